// File: rtl/adsr_voice_scheduler.sv
// ADSR envelope sequencer: per-voice stage/step/count state plus a frame
// scheduler that issues one envelope request per voice on every sample tick.

// Per-voice envelope state. Gate events land at frame start; the envelope
// advances by one sample each time this voice's request is accepted.
module adsr_voice_lane #(
    parameter int STEP_SAMPLES = 480,
    parameter int NUM_STEPS    = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_i,
    input  logic       on_i,
    input  logic       off_i,
    input  logic       adv_i,
    output logic [2:0] stage_o,
    output logic [3:0] step_o
);
    localparam logic [2:0]  ST_IDLE    = 3'd0;
    localparam logic [2:0]  ST_ATTACK  = 3'd1;
    localparam logic [2:0]  ST_DECAY   = 3'd2;
    localparam logic [2:0]  ST_SUSTAIN = 3'd3;
    localparam logic [2:0]  ST_RELEASE = 3'd4;
    localparam logic [15:0] CNT_LAST   = 16'(STEP_SAMPLES - 1);
    localparam logic [3:0]  STEP_LAST  = 4'(NUM_STEPS - 1);

    logic [2:0]  stage_q, stage_d;
    logic [3:0]  step_q, step_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timed;

    assign timed = (stage_q == ST_ATTACK) || (stage_q == ST_DECAY) ||
                   (stage_q == ST_RELEASE);

    // Next state: gate events at frame start (note_on wins), else timed advance.
    always_comb begin
        stage_d = stage_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            if (on_i) begin
                stage_d = ST_ATTACK;
                step_d  = '0;
                cnt_d   = '0;
            end else if (off_i && stage_q != ST_IDLE && stage_q != ST_RELEASE) begin
                stage_d = ST_RELEASE;
                step_d  = '0;
                cnt_d   = '0;
            end
        end else if (adv_i && timed) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (step_q == STEP_LAST) begin
                    step_d = '0;
                    case (stage_q)
                        ST_ATTACK: stage_d = ST_DECAY;
                        ST_DECAY:  stage_d = ST_SUSTAIN;
                        default:   stage_d = ST_IDLE;
                    endcase
                end else begin
                    step_d = step_q + 4'd1;
                end
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Envelope state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= ST_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stage_o = stage_q;
    assign step_o  = step_q;
endmodule

module adsr_voice_scheduler #(
    parameter int NUM_VOICES   = 4,
    parameter int VOICE_W      = 2,
    parameter int STEP_SAMPLES = 480,
    parameter int NUM_STEPS    = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_tick,
    input  logic [NUM_VOICES-1:0] note_on,
    input  logic [NUM_VOICES-1:0] note_off,
    output logic                  env_valid,
    input  logic                  env_ready,
    output logic [VOICE_W-1:0]    env_voice,
    output logic [2:0]            env_stage,
    output logic [3:0]            env_step,
    output logic                  frame_done,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  overrun
);
    typedef enum logic [1:0] {S_WAIT, S_ISSUE, S_DONE} sched_e;

    sched_e                          state_q, state_d;
    logic [VOICE_W-1:0]              idx_q, idx_d;
    logic [NUM_VOICES-1:0]           pend_on_q, pend_off_q;
    logic                            overrun_q;
    logic                            start, accept;
    logic [NUM_VOICES-1:0]           on_eff, off_eff;
    logic [NUM_VOICES-1:0][2:0]      stage_w;
    logic [NUM_VOICES-1:0][3:0]      step_w;

    assign start   = sample_tick && (state_q == S_WAIT);
    assign accept  = env_valid && env_ready;
    // Events arriving on the starting tick cycle count for this frame.
    assign on_eff  = pend_on_q | note_on;
    assign off_eff = pend_off_q | note_off;

    // Scheduler next state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        env_valid  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (sample_tick) begin
                    state_d = S_ISSUE;
                    idx_d   = '0;
                end
            end
            S_ISSUE: begin
                env_valid = 1'b1;
                if (env_ready) begin
                    if (idx_q == VOICE_W'(NUM_VOICES - 1)) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    // Scheduler state, pending gate bits and sticky overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_WAIT;
            idx_q      <= '0;
            pend_on_q  <= '0;
            pend_off_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_on_q  <= start ? '0 : on_eff;
            pend_off_q <= start ? '0 : off_eff;
            overrun_q  <= overrun_q | (sample_tick && state_q != S_WAIT);
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_lane
        adsr_voice_lane #(
            .STEP_SAMPLES(STEP_SAMPLES),
            .NUM_STEPS   (NUM_STEPS)
        ) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .start_i(start),
            .on_i   (on_eff[g]),
            .off_i  (off_eff[g]),
            .adv_i  (accept && idx_q == VOICE_W'(g)),
            .stage_o(stage_w[g]),
            .step_o (step_w[g])
        );
        assign voice_active[g] = (stage_w[g] != 3'd0);
    end

    assign env_voice = idx_q;
    assign env_stage = stage_w[idx_q];
    assign env_step  = step_w[idx_q];
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_adsr_voice_scheduler.sv
// Bench for adsr_voice_scheduler: behavioural model (elapsed-samples-per-stage
// view of each envelope) checked every cycle, plus literal spot checks.
module tb_adsr_voice_scheduler;
    localparam int NV = 4;
    localparam int SS = 4;
    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sample_tick = 1'b0;
    logic [NV-1:0] note_on = '0;
    logic [NV-1:0] note_off = '0;
    logic          env_valid;
    logic          env_ready = 1'b1;
    logic [1:0]    env_voice;
    logic [2:0]    env_stage;
    logic [3:0]    env_step;
    logic          frame_done;
    logic [NV-1:0] voice_active;
    logic          overrun;

    adsr_voice_scheduler #(.NUM_VOICES(NV), .VOICE_W(2), .STEP_SAMPLES(SS), .NUM_STEPS(NS)) dut (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .note_on(note_on),
        .note_off(note_off), .env_valid(env_valid), .env_ready(env_ready),
        .env_voice(env_voice), .env_stage(env_stage), .env_step(env_step),
        .frame_done(frame_done), .voice_active(voice_active), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle_n = 0;
    int fd_count = 0;
    int last_fd = 0;
    int cap_stage [NV];
    int cap_step [NV];

    // Model: stage plus samples elapsed within the stage; step = elapsed / SS.
    int      m_stage [NV];
    int      m_el [NV];
    bit [NV-1:0] m_pon, m_poff;
    int      m_phase;   // 0 waiting, 1 issuing, 2 frame done
    int      m_idx;
    bit      m_ovr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle_n);
        end
    endtask

    function automatic bit timed(input int s);
        return s == 1 || s == 2 || s == 4;
    endfunction

    function automatic int m_step(input int v);
        return timed(m_stage[v]) ? m_el[v] / SS : 0;
    endfunction

    task automatic m_reset();
        for (int v = 0; v < NV; v++) begin m_stage[v] = 0; m_el[v] = 0; end
        m_pon = '0; m_poff = '0; m_phase = 0; m_idx = 0; m_ovr = 1'b0;
    endtask

    task automatic m_adv(input int v);
        if (timed(m_stage[v])) begin
            m_el[v]++;
            if (m_el[v] == SS * NS) begin
                m_el[v] = 0;
                m_stage[v] = (m_stage[v] == 1) ? 2 : (m_stage[v] == 2) ? 3 : 0;
            end
        end
    endtask

    // One clock cycle: drive inputs, step the model, compare after the edge.
    task automatic cyc(input bit tk, input logic [NV-1:0] on, input logic [NV-1:0] off, input bit rdy);
        int old;
        logic [NV-1:0] act;
        sample_tick = tk; note_on = on; note_off = off; env_ready = rdy;
        if (env_valid && rdy) begin
            cap_stage[env_voice] = env_stage;
            cap_step[env_voice]  = env_step;
        end
        old = m_phase;
        if (tk && old != 0) m_ovr = 1'b1;
        if (old == 0 && tk) begin
            for (int v = 0; v < NV; v++) begin
                if (m_pon[v] | on[v]) begin
                    m_stage[v] = 1; m_el[v] = 0;
                end else if ((m_poff[v] | off[v]) && m_stage[v] >= 1 && m_stage[v] <= 3) begin
                    m_stage[v] = 4; m_el[v] = 0;
                end
            end
            m_pon = '0; m_poff = '0; m_phase = 1; m_idx = 0;
        end else begin
            m_pon = m_pon | on; m_poff = m_poff | off;
        end
        if (old == 1 && rdy) begin
            m_adv(m_idx);
            if (m_idx == NV - 1) begin m_phase = 2; m_idx = 0; end
            else m_idx++;
        end
        if (old == 2) m_phase = 0;
        @(posedge clk);
        #1;
        sample_tick = 1'b0; note_on = '0; note_off = '0;
        cycle_n++;
        act = '0;
        for (int v = 0; v < NV; v++) act[v] = (m_stage[v] != 0);
        chk("env_valid", int'(env_valid), int'(m_phase == 1));
        chk("frame_done", int'(frame_done), int'(m_phase == 2));
        chk("voice_active", int'(voice_active), int'(act));
        chk("overrun", int'(overrun), int'(m_ovr));
        if (m_phase == 1) begin
            chk("env_voice", int'(env_voice), m_idx);
            chk("env_stage", int'(env_stage), m_stage[m_idx]);
            chk("env_step", int'(env_step), m_step(m_idx));
        end
        if (frame_done) begin fd_count++; last_fd = cycle_n; end
    endtask

    task automatic frame(input logic [NV-1:0] on, input logic [NV-1:0] off);
        int fd0;
        fd0 = fd_count;
        cyc(1'b1, on, off, 1'b1);
        for (int i = 0; i < 40 && m_phase != 0; i++) cyc(1'b0, '0, '0, 1'b1);
        chk("frame_done_count", fd_count - fd0, 1);
    endtask

    task automatic chk_cap(input string name, input int v, input int st, input int sp);
        chk({name, "_stage"}, cap_stage[v], st);
        chk({name, "_step"}, cap_step[v], sp);
    endtask

    initial begin
        int t0, fd0, stall;
        bit rdy;
        m_reset();
        for (int v = 0; v < NV; v++) begin cap_stage[v] = -1; cap_step[v] = -1; end

        // Reset: every output low while held.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_env_valid", int'(env_valid), 0);
        chk("rst_env_voice", int'(env_voice), 0);
        chk("rst_env_stage", int'(env_stage), 0);
        chk("rst_env_step", int'(env_step), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_voice_active", int'(voice_active), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset_n = 1'b1;
        cyc(1'b0, '0, '0, 1'b1);

        // First frame: four IDLE requests, frame_done on the 5th cycle after tick.
        t0 = cycle_n;
        frame('0, '0);
        chk("first_fd_latency", last_fd - t0, 5);
        for (int v = 0; v < NV; v++) chk_cap("first_idle", v, 0, 0);

        // Full envelope on voices 0,1,2.
        frame(4'b0111, '0);
        chk_cap("att_f1", 1, 1, 0);
        for (int f = 2; f <= 26; f++) begin
            frame('0, '0);
            if (f == 4)  chk_cap("att_f4", 1, 1, 0);
            if (f == 5)  chk_cap("att_f5", 1, 1, 1);
            if (f == 12) chk_cap("att_f12", 1, 1, 2);
            if (f == 13) chk_cap("dec_f13", 1, 2, 0);
            if (f == 25) chk_cap("sus_f25", 1, 3, 0);
            if (f == 26) chk_cap("sus_f26", 0, 3, 0);
        end

        // Simultaneous on/off on voice 0, note_off on IDLE voice 3, release 1 and 2.
        cyc(1'b0, 4'b0001, 4'b1111, 1'b1);
        frame('0, '0);
        chk_cap("simul_v0", 0, 1, 0);
        chk_cap("rel_r1", 1, 4, 0);
        chk_cap("idle_v3", 3, 0, 0);
        chk("idle_v3_active", int'(voice_active[3]), 0);
        for (int r = 2; r <= 5; r++) frame('0, '0);
        chk_cap("rel_r5", 2, 4, 1);
        frame(4'b0100, '0);
        chk_cap("retrig_v2", 2, 1, 0);
        chk_cap("rel_r6", 1, 4, 1);
        for (int r = 7; r <= 12; r++) frame('0, '0);
        chk_cap("rel_r12", 1, 4, 2);
        chk("rel_end_active", int'(voice_active[1]), 0);
        frame('0, '0);
        chk_cap("rel_idle", 1, 0, 0);

        // Backpressure: voice 2 stalled for 3 cycles.
        t0 = cycle_n;
        cyc(1'b1, '0, '0, 1'b1);
        stall = 0;
        for (int i = 0; i < 40 && m_phase != 0; i++) begin
            rdy = !(m_phase == 1 && m_idx == 2 && stall < 3);
            if (!rdy) begin
                stall++;
                chk("bp_voice", int'(env_voice), 2);
            end
            cyc(1'b0, '0, '0, rdy);
        end
        chk("bp_fd_latency", last_fd - t0, 8);

        // Overrun: second tick mid-frame is dropped and sets the sticky flag.
        fd0 = fd_count;
        cyc(1'b1, '0, '0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0);
        cyc(1'b1, '0, '0, 1'b0);
        for (int i = 0; i < 40 && m_phase != 0; i++) cyc(1'b0, '0, '0, 1'b1);
        repeat (5) cyc(1'b0, '0, '0, 1'b1);
        chk("ovr_sticky", int'(overrun), 1);
        chk("ovr_one_frame", fd_count - fd0, 1);

        // Reset mid-issue: env_valid drops before any clock edge.
        cyc(1'b1, '0, '0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(env_valid), 0);
        chk("mid_rst_active", int'(voice_active), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        fd0 = fd_count;
        repeat (4) cyc(1'b0, '0, '0, 1'b1);
        chk("mid_rst_no_fd", fd_count - fd0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 9) == 0,
                ($urandom_range(0, 19) == 0) ? NV'($urandom) : '0,
                ($urandom_range(0, 14) == 0) ? NV'($urandom) : '0,
                $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
